// File: rtl/sad_pkg.sv
// sad_pkg: shared definitions for the motion-vector search controller.
//   - state_e    : controller FSM states (IDLE/ISSUE/DRAIN/DONE)
//   - ncand()    : candidate count of a +/-r square window, (2r+1)^2
//   - mvw()      : signed MV component width able to hold -r..+r
//   - sad_width(): SAD bus width for a given pixel width (8+dwidth)
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int ncand(input int r);
    return (2 * r + 1) * (2 * r + 1);
  endfunction

  function automatic int mvw(input int r);
    return $clog2(r + 1) + 1;
  endfunction

  function automatic int sad_width(input int dwidth);
    return 8 + dwidth;
  endfunction

endpackage

// File: rtl/sad_mv_search_if.sv
// sad_mv_search_if: link between the search controller and the SAD engine.
//   cal_en            issue strobe, one candidate per cycle
//   cand_rdy          reference fetch can serve cand_mvx/cand_mvy this cycle
//   cand_mvx/cand_mvy signed displacement of the candidate being issued
//   sad / sad_vld     engine result stream, returned in issue order
// Handshake: a candidate is transferred in every cycle where cal_en=1, and
// cal_en is only ever raised when cand_rdy=1 (cal_en implies cand_rdy).
// cand_mv* are stable whenever cand_rdy=0. Results carry no backpressure:
// every cycle with sad_vld=1 delivers exactly one result.
// Modports: master = controller, slave = engine/fetch side.
interface sad_mv_search_if
  import sad_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int SEARCH_R = 4
) ();

  localparam int MVW   = mvw(SEARCH_R);
  localparam int SAD_W = sad_width(DWIDTH);

  logic                    cal_en;
  logic                    cand_rdy;
  logic signed [MVW-1:0]   cand_mvx;
  logic signed [MVW-1:0]   cand_mvy;
  logic        [SAD_W-1:0] sad;
  logic                    sad_vld;

  modport master (
    output cal_en, cand_mvx, cand_mvy,
    input  cand_rdy, sad, sad_vld
  );

  modport slave (
    input  cal_en, cand_mvx, cand_mvy,
    output cand_rdy, sad, sad_vld
  );

endinterface

// File: rtl/sad_raster_cnt.sv
// sad_raster_cnt: signed raster walk over a +/-SEARCH_R window.
// x runs -R..+R (inner), y runs -R..+R (outer); wraps to (-R,-R).
//   clk, rst  clock / synchronous active-high reset (to (-R,-R))
//   clr       synchronous restart at (-R,-R)
//   en        advance one position
//   x, y      current position
//   last      current position is (+R,+R)
module sad_raster_cnt #(
  parameter int SEARCH_R = 4,
  parameter int MVW      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic signed [MVW-1:0] x,
  output logic signed [MVW-1:0] y,
  output logic                  last
);

  localparam logic signed [MVW-1:0] R_POS = MVW'(SEARCH_R);
  localparam logic signed [MVW-1:0] R_NEG = MVW'(-SEARCH_R);
  localparam logic signed [MVW-1:0] ONE   = MVW'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= R_NEG;
      y <= R_NEG;
    end else if (en) begin
      if (x == R_POS) begin
        x <= R_NEG;
        y <= (y == R_POS) ? R_NEG : y + ONE;
      end else begin
        x <= x + ONE;
      end
    end
  end

  assign last = (x == R_POS) && (y == R_POS);

endmodule

// File: rtl/sad_mv_search.sv
// sad_mv_search: full-search motion estimation controller.
// Issues every candidate of the +/-SEARCH_R window to the SAD engine in
// raster order, tracks the returning results in the same order and reports
// the minimum SAD and its motion vector.
//   clk, rst            clock / synchronous active-high reset
//   start               begin a search (accepted only in IDLE)
//   eng                 engine link (master side): cal_en, cand_mv*, sad*
//   busy                state != IDLE
//   done                one-cycle pulse, best_* final in that cycle
//   best_sad            raw SAD of the winner
//   best_mvx, best_mvy  winning displacement
//   dbg_state           current FSM state
// Build option: SAD_SEARCH_ZERO_BIAS_EN credits ZERO_BIAS to the (0,0)
// candidate during comparison (clamped at 0); best_sad stays raw.
module sad_mv_search
  import sad_pkg::*;
#(
  parameter int  DWIDTH    = 8,
  parameter int  SEARCH_R  = 4,
  parameter int  ZERO_BIAS = 16,
  localparam int MVW       = mvw(SEARCH_R),
  localparam int SAD_W     = sad_width(DWIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  sad_mv_search_if.master        eng,
  output logic                   busy,
  output logic                   done,
  output logic       [SAD_W-1:0] best_sad,
  output logic signed [MVW-1:0]  best_mvx,
  output logic signed [MVW-1:0]  best_mvy,
  output state_e                 dbg_state
);

  if (ZERO_BIAS < 0 || ZERO_BIAS >= (1 << SAD_W)) begin : g_bias_check
    $error("ZERO_BIAS does not fit the SAD width");
  end

  state_e state, state_nxt;

  logic                  start_acc, issue_en, issue_last;
  logic                  res_acc, res_last, res_fin, res_done;
  logic                  have_best, take;
  logic signed [MVW-1:0] iss_x, iss_y, res_x, res_y;
  logic [SAD_W-1:0]      cand_cmp, inc_cmp;

  assign start_acc = (state == IDLE) && start;
  assign issue_en  = (state == ISSUE) && eng.cand_rdy;
  // Results are only meaningful while a search is open and not yet complete.
  assign res_acc   = eng.sad_vld && (state == ISSUE || state == DRAIN) && !res_done;
  assign res_fin   = res_done || (res_acc && res_last);

  sad_raster_cnt #(.SEARCH_R(SEARCH_R), .MVW(MVW)) u_issue_cnt (
    .clk (clk), .rst (rst), .clr (start_acc), .en (issue_en),
    .x (iss_x), .y (iss_y), .last (issue_last)
  );

  // Results return in issue order, so a second walk regenerates their MVs.
  sad_raster_cnt #(.SEARCH_R(SEARCH_R), .MVW(MVW)) u_res_cnt (
    .clk (clk), .rst (rst), .clr (start_acc), .en (res_acc),
    .x (res_x), .y (res_y), .last (res_last)
  );

  assign eng.cand_mvx = iss_x;
  assign eng.cand_mvy = iss_y;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (issue_en && issue_last) state_nxt = res_fin ? DONE : DRAIN;
      DRAIN:   if (res_fin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    eng.cal_en = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      ISSUE:   eng.cal_en = eng.cand_rdy;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

`ifdef SAD_SEARCH_ZERO_BIAS_EN
  localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS);
  logic [SAD_W-1:0] best_cmp;

  always_comb begin
    cand_cmp = eng.sad;
    if (res_x == '0 && res_y == '0)
      cand_cmp = (eng.sad > BIAS) ? eng.sad - BIAS : '0;
  end

  // The incumbent may be the biased centre, so its compare value is kept
  // apart from the raw SAD that is reported.
  always_ff @(posedge clk) begin
    if (rst || start_acc) best_cmp <= '0;
    else if (take)        best_cmp <= cand_cmp;
  end

  assign inc_cmp = best_cmp;
`else
  assign cand_cmp = eng.sad;
  assign inc_cmp  = best_sad;
`endif

  // Strictly-less keeps the earliest raster candidate on ties.
  assign take = res_acc && (!have_best || cand_cmp < inc_cmp);

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      res_done  <= 1'b0;
      have_best <= 1'b0;
      best_sad  <= '0;
      best_mvx  <= '0;
      best_mvy  <= '0;
    end else begin
      if (res_acc && res_last) res_done <= 1'b1;
      if (take) begin
        have_best <= 1'b1;
        best_sad  <= eng.sad;
        best_mvx  <= res_x;
        best_mvy  <= res_y;
      end
    end
  end

endmodule

// File: tb/tb_sad_mv_search.sv
// tb_sad_mv_search: randomized self-checking bench for sad_mv_search with a
// small window (SEARCH_R=1) and a behavioural SAD engine of variable latency.
module tb_sad_mv_search;
  import sad_pkg::*;

  localparam int DWIDTH    = 8;
  localparam int SEARCH_R  = 1;
  localparam int ZERO_BIAS = 16;
  localparam int SIDE      = 2 * SEARCH_R + 1;
  localparam int NCAND     = SIDE * SIDE;
  localparam int CENTER    = NCAND / 2;
  localparam int MVW       = $clog2(SEARCH_R + 1) + 1;
  localparam int SAD_W     = 8 + DWIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic                  busy, done;
  logic [SAD_W-1:0]      best_sad;
  logic signed [MVW-1:0] best_mvx, best_mvy;
  state_e                dbg_state;

  sad_mv_search_if #(.DWIDTH(DWIDTH), .SEARCH_R(SEARCH_R)) eng_if ();

  sad_mv_search #(.DWIDTH(DWIDTH), .SEARCH_R(SEARCH_R), .ZERO_BIAS(ZERO_BIAS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .eng       (eng_if),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_mvx  (best_mvx),
    .best_mvy  (best_mvy),
    .dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [SAD_W-1:0] sad_tab [NCAND];
  logic [SAD_W-1:0] exp_q [$];   // results owed by the engine, issue order
  int               due_q [$];   // cycle each owed result is returned in
  int  lat = 1;
  int  rdy_mode = 0;             // 0: always ready, 1: 1,0,0 pattern, 2: random
  bit  junk_en = 1'b0;
  int  issue_idx, cal_cnt, done_cnt, first_cal_cyc, done_cyc;
  logic [SAD_W-1:0]      done_sad;
  logic signed [MVW-1:0] done_mvx, done_mvy;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_x(input int i);
    return i % SIDE - SEARCH_R;
  endfunction

  function automatic int exp_y(input int i);
    return i / SIDE - SEARCH_R;
  endfunction

  // Reference: minimum over the raster, earliest index wins ties.
  function automatic void ref_best(output int bidx, output logic [SAD_W-1:0] bsad);
    int key, best_key;
    bidx = -1;
    best_key = 0;
    for (int k = 0; k < NCAND; k++) begin
      key = int'(sad_tab[k]);
`ifdef SAD_SEARCH_ZERO_BIAS_EN
      if (k == CENTER) key = (key > ZERO_BIAS) ? key - ZERO_BIAS : 0;
`endif
      if (bidx < 0 || key < best_key) begin
        bidx = k;
        best_key = key;
      end
    end
    bsad = sad_tab[bidx];
  endfunction

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       eng_if.cand_rdy = 1'b1;
      1:       eng_if.cand_rdy = (cyc % 3 == 0);
      default: eng_if.cand_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Engine model and issue monitor, mid-cycle when DUT outputs are settled.
  always @(negedge clk) begin
    int ix, iy, k;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      eng_if.sad_vld = 1'b0;
    end else begin
      if (eng_if.cal_en) begin
        ix = int'(eng_if.cand_mvx) + SEARCH_R;
        iy = int'(eng_if.cand_mvy) + SEARCH_R;
        k  = iy * SIDE + ix;
        check("cal_en_in_window", issue_idx < NCAND, 1);
        check("issue_mvx", eng_if.cand_mvx, exp_x(issue_idx));
        check("issue_mvy", eng_if.cand_mvy, exp_y(issue_idx));
        exp_q.push_back((k >= 0 && k < NCAND) ? sad_tab[k] : '1);
        due_q.push_back(cyc + lat);
        if (cal_cnt == 0) first_cal_cyc = cyc;
        cal_cnt++;
        issue_idx++;
      end else if (busy && issue_idx < NCAND) begin
        check("stall_mvx", eng_if.cand_mvx, exp_x(issue_idx));
        check("stall_mvy", eng_if.cand_mvy, exp_y(issue_idx));
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        eng_if.sad_vld = 1'b1;
        eng_if.sad     = exp_q.pop_front();
        void'(due_q.pop_front());
      end else if (!busy && junk_en && $urandom_range(0, 1) == 1) begin
        eng_if.sad_vld = 1'b1;
        eng_if.sad     = '0;
      end else begin
        eng_if.sad_vld = 1'b0;
        eng_if.sad     = SAD_W'($urandom);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_sad = best_sad;
        done_mvx = best_mvx;
        done_mvy = best_mvy;
      end
    end
  end

  task automatic begin_search(input int l, input int mode, output int s_cyc);
    lat = l;
    rdy_mode = mode;
    issue_idx = 0;
    cal_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_cal_cyc = -1;
    @(posedge clk);
    #2;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic run_search(input int l, input int mode, input bit extra);
    int s_cyc, bidx;
    logic [SAD_W-1:0] bsad;
    begin_search(l, mode, s_cyc);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      @(posedge clk);
      #2;
      start = extra && issue_idx > 0 && issue_idx < NCAND && $urandom_range(0, 2) == 0;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    ref_best(bidx, bsad);
    check("done_count", done_cnt, 1);
    check("cal_en_count", cal_cnt, NCAND);
    check("done_best_sad", done_sad, bsad);
    check("done_best_mvx", done_mvx, exp_x(bidx));
    check("done_best_mvy", done_mvy, exp_y(bidx));
    check("hold_best_sad", best_sad, bsad);
    check("hold_best_mvx", best_mvx, exp_x(bidx));
    check("hold_best_mvy", best_mvy, exp_y(bidx));
    check("idle_busy", busy, 0);
    if (mode == 0) begin
      check("first_issue_cycle", first_cal_cyc, s_cyc + 1);
      check("search_length", done_cyc - s_cyc + 1, NCAND + l + 2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cal_en"}, eng_if.cal_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_best_sad"}, best_sad, 0);
    check({tag, "_best_mvx"}, best_mvx, 0);
    check({tag, "_best_mvy"}, best_mvy, 0);
    check({tag, "_cand_mvx"}, eng_if.cand_mvx, -SEARCH_R);
    check({tag, "_cand_mvy"}, eng_if.cand_mvy, -SEARCH_R);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s_cyc;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;

    // basic win: descending SADs with a clear minimum at index 5 -> (+1,0)
    for (int k = 0; k < NCAND; k++) sad_tab[k] = SAD_W'(200 - 10 * k);
    sad_tab[5] = 100;
    run_search(1, 0, 1'b0);
    check("basic_sad", best_sad, 100);
    check("basic_mvx", best_mvx, 1);
    check("basic_mvy", best_mvy, 0);

    // ties: earliest raster candidate (-1,-1) wins
    for (int k = 0; k < NCAND; k++) sad_tab[k] = 50;
    run_search(2, 0, 1'b0);
    check("tie_mvx", best_mvx, -1);
    check("tie_mvy", best_mvy, -1);

    // backpressure 1,0,0 pattern
    for (int k = 0; k < NCAND; k++) sad_tab[k] = SAD_W'($urandom_range(40, 900));
    run_search(2, 1, 1'b0);

    // abort mid-drain, then restart
    begin_search(3, 0, s_cyc);
    for (int i = 0; i < 100 && issue_idx < NCAND; i++) begin
      @(posedge clk);
      #2;
    end
    check("abort_reached_drain", issue_idx, NCAND);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("abort_no_done", done_cnt, 0);
    for (int k = 0; k < NCAND; k++) sad_tab[k] = SAD_W'($urandom_range(31, 1000));
    sad_tab[1] = 30;
    run_search(2, 0, 1'b0);
    check("restart_sad", best_sad, 30);

    // start pulses while busy are ignored
    for (int k = 0; k < NCAND; k++) sad_tab[k] = SAD_W'($urandom_range(0, 500));
    run_search(1, 0, 1'b1);

    // zero bias: centre 60 against (1,1) 50
    for (int k = 0; k < NCAND; k++) sad_tab[k] = 255;
    sad_tab[CENTER] = 60;
    sad_tab[NCAND-1] = 50;
    run_search(0, 0, 1'b0);
`ifdef SAD_SEARCH_ZERO_BIAS_EN
    check("bias_sad", best_sad, 60);
    check("bias_mvx", best_mvx, 0);
    check("bias_mvy", best_mvy, 0);
`else
    check("bias_sad", best_sad, 50);
    check("bias_mvx", best_mvx, 1);
    check("bias_mvy", best_mvy, 1);
`endif

    // randomized searches with stray idle results
    junk_en = 1'b1;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 2))
        0: for (int k = 0; k < NCAND; k++) sad_tab[k] = SAD_W'($urandom);
        1: for (int k = 0; k < NCAND; k++) sad_tab[k] = SAD_W'($urandom_range(0, 7));
        default: begin
          for (int k = 0; k < NCAND; k++) sad_tab[k] = SAD_W'($urandom_range(20, 120));
          sad_tab[CENTER] = SAD_W'($urandom_range(20, 60));
        end
      endcase
      run_search($urandom_range(0, 6), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
